// File: rtl/buffer_unpacker_pkg.sv
// Shared definitions for the buffer unpacker.
//   state_e     : FSM encoding (IDLE / EMIT / GAP_WAIT)
//   clog2_min1  : ceil(log2(value)), never less than 1, used to size counters
package buffer_unpacker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EMIT     = 2'd1,
    ST_GAP_WAIT = 2'd2
  } state_e;

  // A counter over 1 or 2 values still needs one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/buffer_unpacker.sv
// buffer_unpacker
//   Drains the read side of a flow buffer one IN_WIDTH word at a time and
//   replays each word as IN_WIDTH/OUT_WIDTH narrower sub-words on a strobe
//   stream, with optional idle cycles between sub-words and a downstream stall.
//
// Ports
//   clk          in   1          clock
//   rst_n        in   1          synchronous, active-low reset
//   read_full    in   1          buffer head valid (already post-pop while read_delete=1)
//   read_data    in   IN_WIDTH   buffer head word (already post-pop while read_delete=1)
//   read_delete  out  1          registered pop strobe, one cycle per captured word
//   out_ready    in   1          downstream accepts a sub-word this cycle
//   out_nd       out  1          registered strobe: out_data valid
//   out_data     out  OUT_WIDTH  registered sub-word
//   busy         out  1          a word is held (FSM not idle)
module buffer_unpacker
  import buffer_unpacker_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 read_full,
  input  logic [IN_WIDTH-1:0]  read_data,
  output logic                 read_delete,
  input  logic                 out_ready,
  output logic                 out_nd,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 busy
);

  localparam int N     = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = clog2_min1(N);
  localparam int GAP_W = clog2_min1(GAP + 1);
  localparam int SLOTS = 2 ** IDX_W;

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N - 1);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  if ((IN_WIDTH % OUT_WIDTH) != 0) begin : g_width_check
    $error("buffer_unpacker: IN_WIDTH (%0d) is not a multiple of OUT_WIDTH (%0d)",
           IN_WIDTH, OUT_WIDTH);
  end

  state_e                state_q;
  logic [IN_WIDTH-1:0]   shreg_q;
  logic [IDX_W-1:0]      idx_q;
  logic [GAP_W-1:0]      gap_cnt_q;
  // Set when the sub-word just emitted was the last of its word, so that
  // GAP_WAIT knows whether to resume emitting or return to IDLE.
  logic                  last_q;

  // Sub-word table indexed by idx_q; padded to a power of two so every idx
  // value selects a defined entry.
  logic [OUT_WIDTH-1:0]  slice_w [SLOTS];

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slice
    if (gi >= N) begin : g_pad
      assign slice_w[gi] = '0;
    end else if (MSB_FIRST) begin : g_msb
      assign slice_w[gi] = shreg_q[IN_WIDTH-1-gi*OUT_WIDTH -: OUT_WIDTH];
    end else begin : g_lsb
      assign slice_w[gi] = shreg_q[gi*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  assign busy = (state_q != ST_IDLE);

  // read_delete is only ever set from registered state plus a sampled
  // read_full, never combinationally, because the buffer muxes on it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      idx_q       <= '0;
      gap_cnt_q   <= '0;
      last_q      <= 1'b0;
      read_delete <= 1'b0;
      out_nd      <= 1'b0;
      out_data    <= '0;
    end else begin
      read_delete <= 1'b0;
      out_nd      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (read_full) begin
            shreg_q     <= read_data;
            idx_q       <= '0;
            read_delete <= 1'b1;
            state_q     <= ST_EMIT;
          end
        end

        ST_EMIT: begin
          if (out_ready) begin
            out_nd   <= 1'b1;
            out_data <= slice_w[idx_q];
            if (idx_q != IDX_LAST) begin
              idx_q <= idx_q + 1'b1;
              if (GAP > 0) begin
                gap_cnt_q <= GAP_RELOAD;
                last_q    <= 1'b0;
                state_q   <= ST_GAP_WAIT;
              end
            end else if (GAP > 0) begin
              gap_cnt_q <= GAP_RELOAD;
              last_q    <= 1'b1;
              state_q   <= ST_GAP_WAIT;
            end else if (read_full) begin
              // Head already shows the next entry: chain words without a bubble.
              shreg_q     <= read_data;
              idx_q       <= '0;
              read_delete <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end

        ST_GAP_WAIT: begin
          if (gap_cnt_q == '0) begin
            state_q <= last_q ? ST_IDLE : ST_EMIT;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_unpacker.sv
// Directed bench: four unpacker configurations, each fed by a small buffer
// model whose head already reflects a same-cycle pop.
//   0: 32->8 MSB first, GAP=0   1: 32->8 LSB first   2: 32->8 GAP=2   3: 8->8
module tb_buffer_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  full, del, rdy, nd, busy;
  logic [31:0] rdata [4];
  logic [7:0]  od [4];

  logic [31:0] mem [4][64];
  int          wr [4];
  int          rd [4];
  int          cyc;
  int          total;
  int          bad;
  int          sel;

  logic [7:0]  oq [$];
  int          oc [$];
  int          dc [$];

  always #5 clk = ~clk;

  buffer_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1), .GAP(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .read_full(full[0]), .read_data(rdata[0]),
    .read_delete(del[0]), .out_ready(rdy[0]), .out_nd(nd[0]), .out_data(od[0]), .busy(busy[0]));

  buffer_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0), .GAP(0)) dut_l (
    .clk(clk), .rst_n(rst_n), .read_full(full[1]), .read_data(rdata[1]),
    .read_delete(del[1]), .out_ready(rdy[1]), .out_nd(nd[1]), .out_data(od[1]), .busy(busy[1]));

  buffer_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1), .GAP(2)) dut_g (
    .clk(clk), .rst_n(rst_n), .read_full(full[2]), .read_data(rdata[2]),
    .read_delete(del[2]), .out_ready(rdy[2]), .out_nd(nd[2]), .out_data(od[2]), .busy(busy[2]));

  buffer_unpacker #(.IN_WIDTH(8), .OUT_WIDTH(8), .MSB_FIRST(1'b1), .GAP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .read_full(full[3]), .read_data(rdata[3][7:0]),
    .read_delete(del[3]), .out_ready(rdy[3]), .out_nd(nd[3]), .out_data(od[3]), .busy(busy[3]));

  // Buffer models: while read_delete is high the head is already the next entry.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      full[k]  = (wr[k] - rd[k]) > int'(del[k]);
      rdata[k] = mem[k][(rd[k] + int'(del[k])) & 63];
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 4; k++) begin
      if (del[k]) rd[k] <= rd[k] + 1;
    end
  end

  // Monitor for the configuration currently under test.
  always @(negedge clk) begin
    if (nd[sel]) begin
      oq.push_back(od[sel]);
      oc.push_back(cyc);
    end
    if (del[sel]) dc.push_back(cyc);
  end

  task automatic push(input int k, input logic [31:0] w);
    mem[k][wr[k] & 63] = w;
    wr[k] = wr[k] + 1;
  endtask

  task automatic clear_log();
    oq.delete();
    oc.delete();
    dc.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      total++; if (del[k] !== 1'b0) begin bad++; $display("FAIL reset_del[%0d] got=%b want=0", k, del[k]); end
      total++; if (nd[k] !== 1'b0) begin bad++; $display("FAIL reset_nd[%0d] got=%b want=0", k, nd[k]); end
      total++; if (od[k] !== 8'h00) begin bad++; $display("FAIL reset_data[%0d] got=%h want=00", k, od[k]); end
      total++; if (busy[k] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d] got=%b want=0", k, busy[k]); end
    end
    $display("reset: outputs checked on 4 instances");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_msb_first();
    logic [7:0] exp [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    int c0;
    sel = 0; clear_log();
    @(negedge clk);
    c0 = cyc;
    push(0, 32'hAABBCCDD);
    repeat (10) @(negedge clk);
    total++; if (oq.size() != 4) begin bad++; $display("FAIL msb_count got=%0d want=4", oq.size()); end
    for (int i = 0; i < 4 && i < oq.size(); i++) begin
      total++; if (oq[i] !== exp[i]) begin bad++; $display("FAIL msb_byte[%0d] got=%h want=%h", i, oq[i], exp[i]); end
      total++; if (oc[i] != c0 + 2 + i) begin bad++; $display("FAIL msb_cycle[%0d] got=%0d want=%0d", i, oc[i] - c0, 2 + i); end
    end
    total++; if (dc.size() != 1) begin bad++; $display("FAIL msb_pops got=%0d want=1", dc.size()); end
    else begin
      total++; if (dc[0] != c0 + 1) begin bad++; $display("FAIL msb_pop_latency got=%0d want=1", dc[0] - c0); end
    end
    $display("msb_first: word AABBCCDD -> %0d sub-words", oq.size());
  endtask

  task automatic test_lsb_queued();
    logic [7:0] exp [8] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
    int c0;
    sel = 1; clear_log();
    @(negedge clk);
    c0 = cyc;
    push(1, 32'h11223344);
    push(1, 32'h55667788);
    repeat (14) @(negedge clk);
    total++; if (oq.size() != 8) begin bad++; $display("FAIL lsb_count got=%0d want=8", oq.size()); end
    for (int i = 0; i < 8 && i < oq.size(); i++) begin
      total++; if (oq[i] !== exp[i]) begin bad++; $display("FAIL lsb_byte[%0d] got=%h want=%h", i, oq[i], exp[i]); end
      total++; if (oc[i] != c0 + 2 + i) begin bad++; $display("FAIL lsb_cycle[%0d] got=%0d want=%0d", i, oc[i] - c0, 2 + i); end
    end
    total++; if (dc.size() != 2) begin bad++; $display("FAIL lsb_pops got=%0d want=2", dc.size()); end
    else begin
      total++; if (dc[1] - dc[0] != 4) begin bad++; $display("FAIL lsb_pop_spacing got=%0d want=4", dc[1] - dc[0]); end
    end
    $display("lsb_queued: two words -> %0d sub-words, %0d pops", oq.size(), dc.size());
  endtask

  task automatic test_gap();
    logic [7:0] exp [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    int c0;
    sel = 2; clear_log();
    @(negedge clk);
    c0 = cyc;
    push(2, 32'h01020304);
    repeat (16) @(negedge clk);
    total++; if (oq.size() != 4) begin bad++; $display("FAIL gap_count got=%0d want=4", oq.size()); end
    for (int i = 0; i < 4 && i < oq.size(); i++) begin
      total++; if (oq[i] !== exp[i]) begin bad++; $display("FAIL gap_byte[%0d] got=%h want=%h", i, oq[i], exp[i]); end
      total++; if (oc[i] != c0 + 2 + 3 * i) begin bad++; $display("FAIL gap_cycle[%0d] got=%0d want=%0d", i, oc[i] - c0, 2 + 3 * i); end
    end
    $display("gap: word 01020304 -> %0d spaced sub-words", oq.size());
  endtask

  task automatic test_stall();
    logic [7:0] exp [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    bit found = 1'b0;
    sel = 0; clear_log();
    @(negedge clk);
    push(0, 32'hAABBCCDD);
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (nd[0]) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL stall_first got=none want=AA within 8 cycles"); end
    rdy[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (nd[0] !== 1'b0) begin bad++; $display("FAIL stall_nd[%0d] got=%b want=0", i, nd[0]); end
    end
    rdy[0] = 1'b1;
    repeat (8) @(negedge clk);
    total++; if (oq.size() != 4) begin bad++; $display("FAIL stall_count got=%0d want=4", oq.size()); end
    for (int i = 0; i < 4 && i < oq.size(); i++) begin
      total++; if (oq[i] !== exp[i]) begin bad++; $display("FAIL stall_byte[%0d] got=%h want=%h", i, oq[i], exp[i]); end
    end
    if (oq.size() == 4) begin
      total++; if (oc[1] - oc[0] != 6) begin bad++; $display("FAIL stall_resume got=%0d want=6", oc[1] - oc[0]); end
      total++; if (oc[3] - oc[1] != 2) begin bad++; $display("FAIL stall_tail got=%0d want=2", oc[3] - oc[1]); end
    end
    $display("stall: 5-cycle hold after AA -> %0d sub-words", oq.size());
  endtask

  task automatic test_byte_stream();
    sel = 3; clear_log();
    @(negedge clk);
    for (int i = 0; i < 16; i++) push(3, 32'(i));
    repeat (24) @(negedge clk);
    total++; if (dc.size() != 16) begin bad++; $display("FAIL bytes_pops got=%0d want=16", dc.size()); end
    for (int i = 1; i < dc.size(); i++) begin
      total++; if (dc[i] != dc[0] + i) begin bad++; $display("FAIL bytes_pop_cycle[%0d] got=%0d want=%0d", i, dc[i] - dc[0], i); end
    end
    total++; if (oq.size() != 16) begin bad++; $display("FAIL bytes_count got=%0d want=16", oq.size()); end
    for (int i = 0; i < 16 && i < oq.size(); i++) begin
      total++; if (oq[i] !== 8'(i)) begin bad++; $display("FAIL bytes_val[%0d] got=%h want=%h", i, oq[i], 8'(i)); end
      total++; if (oc[i] != oc[0] + i) begin bad++; $display("FAIL bytes_cycle[%0d] got=%0d want=%0d", i, oc[i] - oc[0], i); end
    end
    $display("byte_stream: 16 bytes, %0d pops, %0d sub-words", dc.size(), oq.size());
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] exp [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    int seen = 0;
    sel = 0; clear_log();
    @(negedge clk);
    push(0, 32'hAABBCCDD);
    for (int i = 0; i < 12 && seen < 2; i++) begin
      @(negedge clk);
      if (nd[0]) seen++;
    end
    total++; if (seen != 2) begin bad++; $display("FAIL midrst_prefix got=%0d want=2 sub-words", seen); end
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (nd[0] !== 1'b0) begin bad++; $display("FAIL midrst_nd got=%b want=0", nd[0]); end
    total++; if (od[0] !== 8'h00) begin bad++; $display("FAIL midrst_data got=%h want=00", od[0]); end
    total++; if (del[0] !== 1'b0) begin bad++; $display("FAIL midrst_del got=%b want=0", del[0]); end
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy[0]); end
    rst_n = 1'b1;
    clear_log();
    @(negedge clk);
    push(0, 32'h12345678);
    repeat (8) @(negedge clk);
    total++; if (oq.size() != 4) begin bad++; $display("FAIL midrst_count got=%0d want=4", oq.size()); end
    for (int i = 0; i < 4 && i < oq.size(); i++) begin
      total++; if (oq[i] !== exp[i]) begin bad++; $display("FAIL midrst_byte[%0d] got=%h want=%h", i, oq[i], exp[i]); end
    end
    $display("reset_mid_word: next word 12345678 -> %0d sub-words", oq.size());
  endtask

  initial begin
    rst_n = 1'b0;
    rdy   = 4'hF;
    sel   = 0;
    total = 0;
    bad   = 0;
    for (int k = 0; k < 4; k++) wr[k] = 0;
    test_reset();
    test_msb_first();
    test_lsb_queued();
    test_gap();
    test_stall();
    test_byte_stream();
    test_reset_mid_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    for (int k = 0; k < 4; k++) rd[k] = 0;
    cyc = 0;
  end

endmodule
